// File: rtl/switch_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// switch_round_robin_arbiter
//
// Shares one display resource (hex->7-seg converter and its digit) among
// NUM_REQ switch requesters. One requester owns the resource at a time, for at
// most HOLD_CYCLES clocks. Priority then rotates so that every active switch
// gets served in turn.
//
// Ports
//   CLOCK_50_I     in   1         system clock, all state on rising edge
//   RESET_I        in   1         asynchronous active-high reset
//   REQ_I          in   NUM_REQ   raw switch levels, asynchronous to the clock
//   GRANT_O        out  NUM_REQ   one-hot grant, all zero when nobody owns it
//   GRANT_ID_O     out  4         index of the current owner, 4'hF when none
//   BUSY_O         out  1         high while a grant is active
//   GRANT_COUNT_O  out  8         grants issued since reset, saturates at 8'hFF
//
// Parameters
//   NUM_REQ      number of requesters, 2..15 (4'hF is the "no owner" id)
//   HOLD_CYCLES  maximum number of cycles one grant is held, >= 1
//
// Every output comes straight from a register. REQ_I only reaches the FSM
// through a two-flop synchroniser.
// -----------------------------------------------------------------------------
module switch_round_robin_arbiter #(
  parameter int NUM_REQ     = 10,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic               CLOCK_50_I,
  input  logic               RESET_I,
  input  logic [NUM_REQ-1:0] REQ_I,
  output logic [NUM_REQ-1:0] GRANT_O,
  output logic [3:0]         GRANT_ID_O,
  output logic               BUSY_O,
  output logic [7:0]         GRANT_COUNT_O
);

  // Wide enough to hold HOLD_CYCLES itself. The counter only ever loads
  // HOLD_CYCLES-1 and then counts down to zero.
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]         ID_NONE   = 4'hF;
  localparam logic [3:0]         LAST_ID   = 4'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Request synchroniser
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] req_meta_reg;
  logic [NUM_REQ-1:0] req_s_reg;

  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I) begin
      req_meta_reg <= '0;
      req_s_reg    <= '0;
    end else begin
      req_meta_reg <= REQ_I;
      req_s_reg    <= req_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------------
  state_t             state_reg;
  logic [3:0]         ptr_reg;      // highest-priority index for the next pick
  logic [3:0]         owner_reg;    // kept through S_GAP to advance the pointer
  logic [CNT_W-1:0]   hold_cnt_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [3:0]         grant_id_reg;
  logic               busy_reg;
  logic [7:0]         grant_count_reg;

  // ---------------------------------------------------------------------------
  // Round-robin search
  //
  // Candidate gi is the requester gi places after the pointer, with wrap-around.
  // The lowest-numbered candidate whose request is set wins. The just-served
  // owner sits at the very end of that order. A lone requester is still found,
  // because the search wraps back round to it.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0]      cand_hit;
  logic [NUM_REQ-1:0][3:0] cand_idx;
  logic                    pick_valid;
  logic [3:0]              pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [4:0] sum;
      assign sum = {1'b0, ptr_reg} + 5'(gi);
      assign cand_idx[gi] = (sum >= 5'(NUM_REQ)) ? 4'(sum - 5'(NUM_REQ)) : sum[3:0];
      // Use a mask instead of a variable bit-select, so the index width does
      // not have to match $clog2(NUM_REQ).
      assign cand_hit[gi] = |(req_s_reg & (ONE_HOT0 << cand_idx[gi]));
    end
  endgenerate

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ID_NONE;
    // Walk from the back, so the nearest candidate after the pointer is the
    // last one written and therefore wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[i];
      end
    end
  end

  // grant_reg is one-hot on the owner during S_GRANT, so this picks out
  // req_s[owner].
  logic owner_req;
  assign owner_req = |(req_s_reg & grant_reg);

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I) begin
      state_reg       <= S_IDLE;
      ptr_reg         <= 4'd0;
      owner_reg       <= 4'd0;
      hold_cnt_reg    <= '0;
      grant_reg       <= '0;
      grant_id_reg    <= ID_NONE;
      busy_reg        <= 1'b0;
      grant_count_reg <= 8'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pick_valid) begin
            owner_reg    <= pick_idx;
            grant_reg    <= ONE_HOT0 << pick_idx;
            grant_id_reg <= pick_idx;
            busy_reg     <= 1'b1;
            hold_cnt_reg <= HOLD_LOAD;
            if (grant_count_reg != 8'hFF) begin
              grant_count_reg <= grant_count_reg + 8'd1;
            end
            state_reg <= S_GRANT;
          end
        end

        S_GRANT: begin
          // An early release and expiry of the hold time both take the same
          // single exit. The loaded value of HOLD_CYCLES-1 plus the cycle
          // that sees zero gives exactly HOLD_CYCLES grant cycles.
          if (!owner_req || (hold_cnt_reg == '0)) begin
            grant_reg    <= '0;
            grant_id_reg <= ID_NONE;
            busy_reg     <= 1'b0;
            state_reg    <= S_GAP;
          end else begin
            hold_cnt_reg <= hold_cnt_reg - 1'b1;
          end
        end

        S_GAP: begin
          // The owner just served becomes the lowest priority next round.
          ptr_reg   <= (owner_reg == LAST_ID) ? 4'd0 : owner_reg + 4'd1;
          state_reg <= S_IDLE;
        end

        default: begin
          // Unused encoding: drop any grant and return to idle.
          grant_reg    <= '0;
          grant_id_reg <= ID_NONE;
          busy_reg     <= 1'b0;
          state_reg    <= S_IDLE;
        end
      endcase
    end
  end

  assign GRANT_O       = grant_reg;
  assign GRANT_ID_O    = grant_id_reg;
  assign BUSY_O        = busy_reg;
  assign GRANT_COUNT_O = grant_count_reg;

endmodule

// File: tb/tb_switch_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for switch_round_robin_arbiter (NUM_REQ=10, HOLD_CYCLES=4).
// The reference model chooses each winner from the arbitration rule itself:
// it takes the first set request at or after the pointer, modulo NUM_REQ.
// It also saturates the grant count at 255. Outputs are sampled on the
// falling edge of the clock.
// -----------------------------------------------------------------------------
module tb_switch_round_robin_arbiter;
  localparam int N    = 10;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [3:0]   grant_id;
  logic         busy;
  logic [7:0]   gcount;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int model_cnt = 0;

  switch_round_robin_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD)) dut (
    .CLOCK_50_I   (clk),
    .RESET_I      (rst),
    .REQ_I        (req),
    .GRANT_O      (grant),
    .GRANT_ID_O   (grant_id),
    .BUSY_O       (busy),
    .GRANT_COUNT_O(gcount)
  );

  always #5 clk = ~clk;

  // Reference model: the first active requester at or after the pointer,
  // searching circularly.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (r[idx]) return idx;
    end
    return 15;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic void model_advance(input int owner);
    model_ptr = (owner + 1) % N;
    model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    model_cnt = 0;
  endtask

  // Counts falling edges until a grant appears (bounded). While waiting it
  // also records any idle cycle whose outputs are not id=F and busy=0.
  task automatic wait_grant(input int max, output int waited, output bit timed_out,
                            output int idle_bad);
    waited = 0;
    timed_out = 1'b1;
    idle_bad = 0;
    while (waited < max) begin
      @(negedge clk);
      waited++;
      if (grant != '0) begin
        timed_out = 1'b0;
        break;
      end
      if (grant_id !== 4'hF || busy !== 1'b0) idle_bad++;
    end
  endtask

  // Called on the first falling edge of a grant. Returns the grant length and
  // the number of cycles that were inconsistent. Ends on the first falling
  // edge with no grant.
  task automatic measure_grant(output logic [3:0] id, output logic [N-1:0] gv,
                               output logic [7:0] cnt, output int len, output int bad);
    id  = grant_id;
    gv  = grant;
    cnt = gcount;
    len = 1;
    bad = (busy !== 1'b1) ? 1 : 0;
    while (len < 50) begin
      @(negedge clk);
      if (grant == '0) break;
      if (grant !== gv || grant_id !== id || busy !== 1'b1) bad++;
      len++;
    end
    if (grant_id !== 4'hF || busy !== 1'b0) bad++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int w; bit to; int ib;
    do_reset();
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %h expected 000", grant); end
    checks++; if (grant_id !== 4'hF) begin errors++; $display("FAIL reset_id: got %h expected f", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (gcount !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", gcount); end
    req = 10'h001;
    wait_grant(20, w, to, ib);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL reset_pregrant_timeout: got timeout expected grant"); end
    // Assert reset between edges. The outputs must clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL async_grant: got %h expected 000", grant); end
    checks++; if (grant_id !== 4'hF) begin errors++; $display("FAIL async_id: got %h expected f", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
    checks++; if (gcount !== 8'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", gcount); end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    $display("test_reset: async reset cleared outputs between edges");
  endtask

  task automatic test_single_hold();
    int w; bit to; int ib; logic [3:0] id; logic [N-1:0] gv; logic [7:0] cnt; int len; int bad;
    do_reset();
    req = 10'h008;
    for (int g = 0; g < 3; g++) begin
      wait_grant(20, w, to, ib);
      checks++; if (to || w != ((g == 0) ? 3 : 2)) begin errors++; $display("FAIL single_wait%0d: got %0d expected %0d", g, w, (g == 0) ? 3 : 2); end
      measure_grant(id, gv, cnt, len, bad);
      model_advance(3);
      checks++; if (id !== 4'd3 || gv !== 10'h008) begin errors++; $display("FAIL single_id%0d: got id %0d vec %h expected 3 008", g, id, gv); end
      checks++; if (len != HOLD) begin errors++; $display("FAIL single_len%0d: got %0d expected %0d", g, len, HOLD); end
      checks++; if (cnt !== 8'(model_cnt)) begin errors++; $display("FAIL single_cnt%0d: got %0d expected %0d", g, cnt, model_cnt); end
      checks++; if (bad != 0 || ib != 0) begin errors++; $display("FAIL single_consistency%0d: got %0d expected 0", g, bad + ib); end
      $display("test_single_hold: grant %0d id %0d len %0d wait %0d", g, id, len, w);
    end
  endtask

  task automatic test_all_requests();
    int w; bit to; int ib; logic [3:0] id; logic [N-1:0] gv; logic [7:0] cnt; int len; int bad; int exp;
    do_reset();
    req = 10'h3FF;
    for (int g = 0; g < 11; g++) begin
      exp = model_pick(req, model_ptr);
      wait_grant(20, w, to, ib);
      checks++; if (to || w != ((g == 0) ? 3 : 2)) begin errors++; $display("FAIL all_wait%0d: got %0d expected %0d", g, w, (g == 0) ? 3 : 2); end
      measure_grant(id, gv, cnt, len, bad);
      model_advance(exp);
      checks++; if (id !== 4'(exp) || gv !== onehot(exp)) begin errors++; $display("FAIL all_id%0d: got %0d expected %0d", g, id, exp); end
      checks++; if (len != HOLD || bad != 0) begin errors++; $display("FAIL all_len%0d: got %0d (bad %0d) expected %0d", g, len, bad, HOLD); end
      checks++; if (cnt !== 8'(model_cnt)) begin errors++; $display("FAIL all_cnt%0d: got %0d expected %0d", g, cnt, model_cnt); end
      $display("test_all_requests: grant %0d id %0d count %0d", g, id, cnt);
    end
  endtask

  task automatic test_wrap();
    int w; bit to; int ib; logic [3:0] id; logic [N-1:0] gv; logic [7:0] cnt; int len; int bad; int exp;
    do_reset();
    req = 10'h201;
    for (int g = 0; g < 5; g++) begin
      exp = model_pick(req, model_ptr);
      wait_grant(20, w, to, ib);
      checks++; if (to) begin errors++; $display("FAIL wrap_timeout%0d: got timeout expected grant", g); end
      measure_grant(id, gv, cnt, len, bad);
      model_advance(exp);
      checks++; if (id !== 4'(exp) || len != HOLD) begin errors++; $display("FAIL wrap_id%0d: got id %0d len %0d expected %0d %0d", g, id, len, exp, HOLD); end
      $display("test_wrap: grant %0d id %0d", g, id);
    end
  endtask

  task automatic test_early_release();
    int w; bit to; int ib; logic [3:0] id; logic [N-1:0] gv; logic [7:0] cnt; int len; int bad;
    do_reset();
    req = 10'h020;
    wait_grant(20, w, to, ib);
    checks++; if (to) begin errors++; $display("FAIL early_timeout: got timeout expected grant"); end
    req = '0;  // drop after the first grant cycle
    measure_grant(id, gv, cnt, len, bad);
    // The drop takes two synchroniser stages and then one FSM edge to act.
    checks++; if (len != 3) begin errors++; $display("FAIL early_len: got %0d expected 3", len); end
    checks++; if (id !== 4'd5 || cnt !== 8'd1 || bad != 0) begin errors++; $display("FAIL early_id_cnt: got id %0d cnt %0d bad %0d expected 5 1 0", id, cnt, bad); end
    wait_grant(10, w, to, ib);
    checks++; if (!to || ib != 0) begin errors++; $display("FAIL early_idle: got timeout %0b idle_bad %0d expected 1 0", to, ib); end
    checks++; if (gcount !== 8'd1) begin errors++; $display("FAIL early_final_cnt: got %0d expected 1", gcount); end
    $display("test_early_release: id %0d len %0d", id, len);
  endtask

  task automatic test_reset_mid_grant();
    int w; bit to; int ib; logic [3:0] id; logic [N-1:0] gv; logic [7:0] cnt; int len; int bad;
    do_reset();
    req = 10'h3FF;
    for (int g = 0; g < 4; g++) begin
      wait_grant(20, w, to, ib);
      measure_grant(id, gv, cnt, len, bad);
    end
    wait_grant(20, w, to, ib);
    checks++; if (to || grant_id !== 4'd4) begin errors++; $display("FAIL mid_pre_id: got %0d expected 4", grant_id); end
    #2 rst = 1'b1;
    #1;
    checks++; if (grant !== '0 || grant_id !== 4'hF || busy !== 1'b0 || gcount !== 8'd0) begin
      errors++; $display("FAIL mid_async: got %h %h %b %0d expected 000 f 0 0", grant, grant_id, busy, gcount);
    end
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    model_cnt = 0;
    wait_grant(20, w, to, ib);
    checks++; if (to || w != 3) begin errors++; $display("FAIL mid_latency: got %0d expected 3", w); end
    checks++; if (grant_id !== 4'(model_pick(req, model_ptr)) || gcount !== 8'd1) begin
      errors++; $display("FAIL mid_restart: got id %0d cnt %0d expected 0 1", grant_id, gcount);
    end
    $display("test_reset_mid_grant: restart id %0d count %0d", grant_id, gcount);
  endtask

  task automatic test_saturation();
    int w; bit to; int ib; logic [3:0] id; logic [N-1:0] gv; logic [7:0] cnt; int len; int bad;
    do_reset();
    req = 10'h001;
    for (int g = 0; g < 300; g++) begin
      wait_grant(20, w, to, ib);
      measure_grant(id, gv, cnt, len, bad);
      model_advance(0);
      checks++; if (to || cnt !== 8'(model_cnt)) begin errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", g, cnt, model_cnt); end
    end
    checks++; if (gcount !== 8'hFF) begin errors++; $display("FAIL sat_final: got %0d expected 255", gcount); end
    $display("test_saturation: 300 grants, count %0d", gcount);
  endtask

  task automatic test_random();
    int w; bit to; int ib; logic [3:0] id; logic [N-1:0] gv; logic [7:0] cnt; int len; int bad; int exp;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      req = N'($urandom_range(1, 1023));
      for (int g = 0; g < 10; g++) begin
        exp = model_pick(req, model_ptr);
        wait_grant(20, w, to, ib);
        checks++; if (to || w != ((g == 0) ? 3 : 2) || ib != 0) begin errors++; $display("FAIL rand_wait%0d_%0d: got %0d expected %0d", it, g, w, (g == 0) ? 3 : 2); end
        // Change the other requests during the grant. The owner keeps its
        // request, so the grant runs the full hold time.
        if ($urandom_range(0, 1) == 1) req = N'($urandom) | onehot(exp);
        measure_grant(id, gv, cnt, len, bad);
        model_advance(exp);
        checks++; if (id !== 4'(exp) || gv !== onehot(exp)) begin errors++; $display("FAIL rand_id%0d_%0d: got %0d expected %0d", it, g, id, exp); end
        checks++; if (len != HOLD || bad != 0 || cnt !== 8'(model_cnt)) begin
          errors++; $display("FAIL rand_len_cnt%0d_%0d: got len %0d cnt %0d expected %0d %0d", it, g, len, cnt, HOLD, model_cnt);
        end
        $display("test_random: iter %0d grant %0d req %h id %0d", it, g, req, id);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_all_requests();
    test_wrap();
    test_early_release();
    test_reset_mid_grant();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
